// File: rtl/div_issue_ctrl_pkg.sv
// rtl/div_issue_ctrl_pkg.sv - shared types and helpers for the RV64M divide issue controller
package div_issue_ctrl_pkg;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } div_state_e;

    // DIV and REM with the same operands share a key, so one divider run serves both
    typedef struct packed {
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic        is_w;
        logic        uns;
    } cache_key_t;

    function automatic logic [63:0] select_result(input logic [63:0] quot,
                                                  input logic [63:0] rem,
                                                  input logic        is_rem,
                                                  input logic        is_w);
        logic [63:0] r;
        r = is_rem ? rem : quot;
        return is_w ? {{32{r[31]}}, r[31:0]} : r;
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// rtl/div_result_cache.sv - one-entry quotient/remainder cache keyed on operands and signedness
module div_result_cache
    import div_issue_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  cache_key_t  lookup_key_i,
    input  logic        wr_en_i,
    input  cache_key_t  wr_key_i,
    input  logic [63:0] wr_quot_i,
    input  logic [63:0] wr_rem_i,
    output logic        hit_o,
    output logic [63:0] quot_o,
    output logic [63:0] rem_o
);

    generate
        if (CACHE_EN) begin : g_cache
            cache_key_t  key_q;
            logic        valid_q;
            logic [63:0] quot_q;
            logic [63:0] rem_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    key_q   <= '0;
                    quot_q  <= '0;
                    rem_q   <= '0;
                end else if (wr_en_i) begin
                    valid_q <= 1'b1;
                    key_q   <= wr_key_i;
                    quot_q  <= wr_quot_i;
                    rem_q   <= wr_rem_i;
                end
            end

            assign hit_o  = valid_q && (key_q == lookup_key_i);
            assign quot_o = quot_q;
            assign rem_o  = rem_q;
        end else begin : g_nocache
            assign hit_o  = 1'b0;
            assign quot_o = '0;
            assign rem_o  = '0;
        end
    endgenerate

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage issue/stall/result controller for the multi-cycle divider
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic [1:0]   req_op,
    input  logic         req_is_w,
    input  logic [63:0]  req_rs1,
    input  logic [63:0]  req_rs2,
    input  logic         flush,
    output logic         busy,
    output logic         out_valid,
    output logic [63:0]  out_data,
    output logic         div_valid,
    output logic         div_sign,
    output logic         div_32,
    output logic [63:0]  div_rs1,
    output logic [63:0]  div_rs2,
    input  logic         div_ready,
    input  logic [127:0] div_result
);

    div_state_e  state_q;
    logic [1:0]  op_q;
    logic        is_w_q;
    logic [63:0] rs1_q;
    logic [63:0] rs2_q;
    logic        div_valid_q;
    logic        out_valid_q;
    logic [63:0] out_data_q;

    cache_key_t  req_key;
    cache_key_t  issue_key;
    logic        hit;
    logic        cache_wr;
    logic [63:0] cache_quot;
    logic [63:0] cache_rem;

    assign req_key   = '{rs1: req_rs1, rs2: req_rs2, is_w: req_is_w, uns: req_op[0]};
    assign issue_key = '{rs1: rs1_q, rs2: rs2_q, is_w: is_w_q, uns: op_q[0]};
    assign cache_wr  = (state_q == ST_RUN) && div_ready && !flush;

    div_result_cache #(.CACHE_EN(CACHE_EN)) u_cache (
        .clk          (clk),
        .rst          (rst),
        .lookup_key_i (req_key),
        .wr_en_i      (cache_wr),
        .wr_key_i     (issue_key),
        .wr_quot_i    (div_result[63:0]),
        .wr_rem_i     (div_result[127:64]),
        .hit_o        (hit),
        .quot_o       (cache_quot),
        .rem_o        (cache_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= DIV_OP_DIV;
            is_w_q      <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            div_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && !flush) begin
                        if (hit) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= select_result(cache_quot, cache_rem, req_op[1], req_is_w);
                        end else begin
                            op_q        <= req_op;
                            is_w_q      <= req_is_w;
                            rs1_q       <= req_rs1;
                            rs2_q       <= req_rs2;
                            div_valid_q <= 1'b1;
                            state_q     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (div_ready) begin
                        div_valid_q <= 1'b0;
                        if (flush) begin
                            state_q <= ST_IDLE;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= select_result(div_result[63:0], div_result[127:64],
                                                         op_q[1], is_w_q);
                            state_q     <= ST_DONE;
                        end
                    end else if (flush) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                // the divider only clears its counter on ready, so keep valid up until then
                ST_DRAIN: begin
                    if (div_ready) begin
                        div_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN) ||
                       ((state_q == ST_IDLE) && req_valid && !hit && !flush);
    assign out_valid = out_valid_q && !flush;
    assign out_data  = out_data_q;
    assign div_valid = div_valid_q;
    assign div_sign  = ~op_q[0];
    assign div_32    = is_w_q;
    assign div_rs1   = rs1_q;
    assign div_rs2   = rs2_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl with a behavioural divider
module tb_div_issue_ctrl;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic [1:0]   req_op;
    logic         req_is_w;
    logic [63:0]  req_rs1;
    logic [63:0]  req_rs2;
    logic         flush;
    logic         busy;
    logic         out_valid;
    logic [63:0]  out_data;
    logic         div_valid;
    logic         div_sign;
    logic         div_32;
    logic [63:0]  div_rs1;
    logic [63:0]  div_rs2;
    logic         div_ready;
    logic [127:0] div_result;

    int n_checks = 0;
    int n_fail   = 0;

    div_issue_ctrl #(.CACHE_EN(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_is_w   (req_is_w),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .flush      (flush),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .div_valid  (div_valid),
        .div_sign   (div_sign),
        .div_32     (div_32),
        .div_rs1    (div_rs1),
        .div_rs2    (div_rs2),
        .div_ready  (div_ready),
        .div_result (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in: RISC-V semantics, counter 0..66, same-cycle ready on zero divisor/overflow
    function automatic logic [128:0] div_model(input logic [63:0] a, input logic [63:0] b,
                                               input logic sgn, input logic w);
        logic [63:0] q, r;
        logic [31:0] a32, b32, q32, r32;
        logic        fast;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            fast = (b32 == 32'd0) || (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32;
            end else if (fast) begin
                q32 = a32; r32 = 32'd0;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32; r32 = a32 % b32;
            end
            q = {32'd0, q32};
            r = {32'd0, r32};
        end else begin
            fast = (b == 64'd0) || (sgn && a == 64'h8000_0000_0000_0000 && b == '1);
            if (b == 64'd0) begin
                q = '1; r = a;
            end else if (fast) begin
                q = a; r = 64'd0;
            end else if (sgn) begin
                q = $signed(a) / $signed(b); r = $signed(a) % $signed(b);
            end else begin
                q = a / b; r = a % b;
            end
        end
        return {fast, r, q};
    endfunction

    logic [128:0] model_out;
    int           div_cnt;
    assign model_out  = div_model(div_rs1, div_rs2, div_sign, div_32);
    assign div_result = model_out[127:0];
    assign div_ready  = div_valid && (model_out[128] || div_cnt == 66);

    always @(posedge clk) begin
        if (rst || !div_valid || div_ready) div_cnt <= 0;
        else                                div_cnt <= div_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Presents one op, holds it while busy, returns latency (-1 on timeout), data and busy cycles
    task automatic run_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                          input logic [63:0] b, output int lat, output logic [63:0] data,
                          output int busy_cyc, output logic saw_dv);
        logic released;
        req_valid = 1'b1; req_op = op; req_is_w = w; req_rs1 = a; req_rs2 = b;
        lat = -1; data = '0; busy_cyc = 0; saw_dv = 1'b0; released = 1'b0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (div_valid) saw_dv = 1'b1;
            if (out_valid && lat < 0) begin
                lat  = cyc;
                data = out_data;
            end
            if (!busy) released = 1'b1;
            @(posedge clk); #1;
            if (released) req_valid = 1'b0;
            if (lat >= 0 && released) break;
        end
        req_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t        vecs[10];
    int          lat, busy_cyc;
    logic [63:0] data;
    logic        saw_dv;
    logic        seen_out, dv67, dv68, busy67, busy68, dv2, busy2;

    task automatic apply(input string name, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
        run_op(op, w, a, b, lat, data, busy_cyc, saw_dv);
        check({name, " data"}, data, exp);
        check({name, " latency"}, 64'(lat), 64'(exp_lat));
        check({name, " busy cycles"}, 64'(busy_cyc), 64'(exp_lat == 1 ? 0 : exp_lat));
        check({name, " div_valid seen"}, {63'd0, saw_dv}, {63'd0, exp_lat != 1});
    endtask

    initial begin
        vecs[0] = '{"DIV 20/-3",      2'b00, 1'b0, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 68};
        vecs[1] = '{"REM 20/-3 hit",  2'b10, 1'b0, 64'd20, -64'sd3, 64'd2, 1};
        vecs[2] = '{"DIVU 5/0",       2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
        vecs[3] = '{"REMU 5/0",       2'b11, 1'b0, 64'd5, 64'd0, 64'd5, 1};
        vecs[4] = '{"DIVW ovf",       2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF,
                    64'hFFFF_FFFF_8000_0000, 2};
        vecs[5] = '{"REMW ovf hit",   2'b10, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1};
        vecs[6] = '{"DIVUW",          2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0, 64'h10,
                    64'h0000_0000_0FFF_FFFF, 68};
        vecs[7] = '{"REMW -7/2",      2'b10, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 68};
        vecs[8] = '{"DIVW -7/2 hit",  2'b00, 1'b1, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1};
        vecs[9] = '{"DIV -7/2 nonW",  2'b00, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 68};

        rst = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_is_w = 1'b0;
        req_rs1 = '0; req_rs2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset out_valid", {63'd0, out_valid}, 64'd0);
        check("reset div_valid", {63'd0, div_valid}, 64'd0);
        check("reset out_data", out_data, 64'd0);
        check("reset div_rs1", div_rs1, 64'd0);
        check("reset div_rs2", div_rs2, 64'd0);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++)
            apply(vecs[i].name, vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Flush mid-run: drains until the divider's ready, no result, no cache write
        req_valid = 1'b1; req_op = 2'b00; req_is_w = 1'b0; req_rs1 = 64'd100; req_rs2 = 64'd7;
        seen_out = 1'b0; dv67 = 1'b0; dv68 = 1'b1; busy67 = 1'b0; busy68 = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            if (cyc == 10) begin flush = 1'b1; req_valid = 1'b0; end
            if (cyc == 11) flush = 1'b0;
            @(negedge clk);
            if (out_valid) seen_out = 1'b1;
            if (cyc == 67) begin dv67 = div_valid; busy67 = busy; end
            if (cyc == 68) begin dv68 = div_valid; busy68 = busy; end
            @(posedge clk); #1;
        end
        check("flush no out_valid", {63'd0, seen_out}, 64'd0);
        check("drain div_valid c67", {63'd0, dv67}, 64'd1);
        check("drain div_valid c68", {63'd0, dv68}, 64'd0);
        check("drain busy c67", {63'd0, busy67}, 64'd1);
        check("drain busy c68", {63'd0, busy68}, 64'd0);
        apply("DIVU 100/7", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 68);
        apply("DIV 100/7 after drain", 2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 68);

        // Flush in the same cycle as a fast-path ready: result discarded, straight to IDLE
        req_valid = 1'b1; req_op = 2'b01; req_is_w = 1'b0; req_rs1 = 64'd9; req_rs2 = 64'd0;
        seen_out = 1'b0; dv2 = 1'b1; busy2 = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (cyc == 1) begin flush = 1'b1; req_valid = 1'b0; end
            if (cyc == 2) flush = 1'b0;
            @(negedge clk);
            if (out_valid) seen_out = 1'b1;
            if (cyc == 2) begin dv2 = div_valid; busy2 = busy; end
            @(posedge clk); #1;
        end
        check("flush+ready no out_valid", {63'd0, seen_out}, 64'd0);
        check("flush+ready div_valid c2", {63'd0, dv2}, 64'd0);
        check("flush+ready busy c2", {63'd0, busy2}, 64'd0);
        apply("REMU 9/0 not cached", 2'b11, 1'b0, 64'd9, 64'd0, 64'd9, 2);

        // Reset at cycle 30 of a running divide
        req_valid = 1'b1; req_op = 2'b00; req_is_w = 1'b0; req_rs1 = 64'd1000; req_rs2 = 64'd3;
        for (int cyc = 0; cyc < 32; cyc++) begin
            if (cyc == 30) begin rst = 1'b1; req_valid = 1'b0; end
            if (cyc == 31) rst = 1'b0;
            @(negedge clk);
            if (cyc == 31) begin
                check("rst busy", {63'd0, busy}, 64'd0);
                check("rst out_valid", {63'd0, out_valid}, 64'd0);
                check("rst div_valid", {63'd0, div_valid}, 64'd0);
                check("rst out_data", out_data, 64'd0);
                check("rst div_rs1", div_rs1, 64'd0);
                check("rst div_rs2", div_rs2, 64'd0);
            end
            @(posedge clk); #1;
        end
        apply("DIVW 7/2 after rst", 2'b00, 1'b1, 64'd7, 64'd2, 64'd3, 68);
        apply("REM 20/-3 cache cleared", 2'b10, 1'b0, 64'd20, -64'sd3, 64'd2, 68);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
